// File: rtl/rd_req_arbiter.sv
// Round-robin arbiter merging per-channel DMA read requests into one engine port,
// with per-channel outstanding-request credit tracking and blocking detection.
`ifndef DMA_HEAD_W
`define DMA_HEAD_W 128
`endif

module rd_req_arbiter #(
  parameter int CHNL_NUM   = 4,
  parameter int MAX_OUTSTD = 8
) (
  input  logic                             dma_clk,
  input  logic                             rst_n,
  input  logic [CHNL_NUM-1:0]              chnl_req_valid,
  input  logic [CHNL_NUM*`DMA_HEAD_W-1:0]  chnl_req_head,
  output logic [CHNL_NUM-1:0]              chnl_req_ready,
  output logic                             rd_req_valid,
  output logic [`DMA_HEAD_W-1:0]           rd_req_head,
  input  logic                             rd_req_ready,
  input  logic                             cpl_done_valid,
  input  logic [7:0]                       cpl_done_chnl,
  output logic                             chnl_valid,
  output logic                             chnl_avail,
  output logic                             outstd_err
);

  localparam int              HW       = `DMA_HEAD_W;
  localparam int              IDX_W    = $clog2(CHNL_NUM);
  localparam logic [3:0]      MAX_CNT  = 4'(MAX_OUTSTD);
  localparam logic [HW-1:0]   TOP_MASK = {8'hFF, {(HW-8){1'b0}}};

  typedef enum logic {ST_ARB, ST_HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_last_grant;
  logic [3:0]         r_cnt [CHNL_NUM];
  logic [HW-1:0]      r_head;
  logic               r_err;

  logic [CHNL_NUM-1:0] w_elig, w_ready, w_inc, w_dec;
  logic                w_found, w_accept, w_underflow, w_bad_chnl, w_avail;
  logic [IDX_W-1:0]    w_grant;
  logic [HW-1:0]       w_sel_head, w_cap_head;

  // Search starts just after the previous winner so every channel gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < CHNL_NUM; i++)
      w_elig[i] = chnl_req_valid[i] && (r_cnt[i] < MAX_CNT);
    for (int k = 1; k <= CHNL_NUM; k++) begin
      if (!w_found && w_elig[(int'(r_last_grant) + k) % CHNL_NUM]) begin
        w_found = 1'b1;
        w_grant = IDX_W'((int'(r_last_grant) + k) % CHNL_NUM);
      end
    end
  end

  assign w_accept = rst_n && (r_state == ST_ARB) && w_found;

  always_comb begin
    w_sel_head  = '0;
    w_underflow = 1'b0;
    w_avail     = 1'b1;
    for (int i = 0; i < CHNL_NUM; i++) begin
      w_ready[i] = w_accept && (w_grant == IDX_W'(i));
      w_inc[i]   = w_ready[i];
      w_dec[i]   = cpl_done_valid && (cpl_done_chnl == 8'(i));
      if (w_ready[i])
        w_sel_head = chnl_req_head[i*HW +: HW];
      if (w_dec[i] && (r_cnt[i] == 4'd0))
        w_underflow = 1'b1;
      if (r_last_grant == IDX_W'(i))
        w_avail = (r_cnt[i] < MAX_CNT);
    end
  end

  // The channel-number field is overwritten with the grant so the engine can route completions.
  assign w_cap_head = (w_sel_head & ~TOP_MASK) | {8'(w_grant), {(HW-8){1'b0}}};
  assign w_bad_chnl = cpl_done_valid && (cpl_done_chnl >= 8'(CHNL_NUM));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:  if (w_accept)     w_state_nxt = ST_HOLD;
      ST_HOLD: if (rd_req_ready) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ARB;
      r_last_grant <= IDX_W'(CHNL_NUM - 1);
      r_head       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_head       <= w_cap_head;
      end else if ((r_state == ST_HOLD) && rd_req_ready) begin
        r_head <= '0;
      end
      if (w_underflow || w_bad_chnl)
        r_err <= 1'b1;
    end
  end

  // A completion that coincides with a new accept cancels out; an underflowing one is dropped.
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHNL_NUM; i++)
        r_cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < CHNL_NUM; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + 4'd1;
        else if (!w_inc[i] && w_dec[i] && (r_cnt[i] != 4'd0))
          r_cnt[i] <= r_cnt[i] - 4'd1;
      end
    end
  end

  assign chnl_req_ready = w_ready;
  assign rd_req_valid   = (r_state == ST_HOLD);
  assign rd_req_head    = r_head;
  assign chnl_valid     = (r_state == ST_HOLD);
  assign chnl_avail     = w_avail;
  assign outstd_err     = r_err;

endmodule

// File: doc/rd_req_arbiter.md
RD_REQ_ARBITER -- requirements
Module: rd_req_arbiter

Interface
REQ-001 Parameter CHNL_NUM, default 4: number of DMA read requesters; legal range 2..8.
REQ-002 Parameter MAX_OUTSTD, default 8: maximum accepted, uncompleted read requests per channel; legal range 1..15.
REQ-003 Port dma_clk  in  1  is the single clock; all state is on its rising edge.
REQ-004 Port rst_n  in  1  is the asynchronous, active-low reset.
REQ-005 Port chnl_req_valid  in  CHNL_NUM  carries per-channel request valid.
REQ-006 Port chnl_req_head  in  CHNL_NUM*`DMA_HEAD_W  carries per-channel request heads; channel i is slice [i*`DMA_HEAD_W +: `DMA_HEAD_W], layout {chnl_num[127:120], rsvd, addr[95:32], rsvd, byte_len[12:0]}.
REQ-007 Port chnl_req_ready  out  CHNL_NUM  carries per-channel accept.
REQ-008 Port rd_req_valid  out  1  is the request valid toward the read-request engine.
REQ-009 Port rd_req_head  out  `DMA_HEAD_W  is the granted head.
REQ-010 Port rd_req_ready  in  1  is the engine accept.
REQ-011 Port cpl_done_valid  in  1  is a one-cycle pulse: one read request of channel cpl_done_chnl has fully completed.
REQ-012 Port cpl_done_chnl  in  8  is the completing channel index.
REQ-013 Port chnl_valid  out  1  is the blocking-detection valid toward the engine.
REQ-014 Port chnl_avail  out  1  is the blocking-detection available toward the engine.
REQ-015 Port outstd_err  out  1  is a sticky credit-underflow error flag.

Function
REQ-016 The FSM SHALL have two states: ARB (reset state) and HOLD.
REQ-017 Eligibility: in ARB, channel i SHALL be eligible when chnl_req_valid[i]=1 and outstd_cnt[i] < MAX_OUTSTD.
REQ-018 Round robin: in ARB, the grant SHALL go to the first eligible channel searching from last_grant+1 upward, wrapping modulo CHNL_NUM; last_grant resets to CHNL_NUM-1, so channel 0 wins first.
REQ-019 Accept: chnl_req_ready SHALL be a combinational one-hot of the grant while in ARB, and all-zero in HOLD.
REQ-020 Capture: in the accept cycle, the block SHALL register the granted head with bits [127:120] replaced by the granted index, set last_grant to that index, and move to HOLD.
REQ-021 No eligible channel: the FSM SHALL stay in ARB and all chnl_req_ready SHALL be 0.
REQ-022 In HOLD, rd_req_valid SHALL be 1 and rd_req_head SHALL be held stable until rd_req_ready=1; on that cycle the FSM SHALL return to ARB.
REQ-023 Throughput: sustained throughput SHALL be at most one request per 2 cycles; rd_req_valid SHALL rise exactly 1 cycle after the accept.
REQ-024 rd_req_head SHALL be 0 whenever the FSM is in ARB.
REQ-025 Counter increment: outstd_cnt[i] (4-bit) SHALL increment by 1 on the accept of channel i.
REQ-026 Counter decrement: outstd_cnt[i] SHALL decrement by 1 on cpl_done_valid with cpl_done_chnl=i.
REQ-027 Simultaneous increment and decrement on the same channel SHALL leave outstd_cnt[i] unchanged.
REQ-028 Underflow: a decrement when outstd_cnt[i]=0 SHALL be ignored (the counter stays 0) and SHALL set outstd_err.
REQ-029 A cpl_done_valid with cpl_done_chnl >= CHNL_NUM SHALL be ignored and SHALL set outstd_err.
REQ-030 outstd_err SHALL clear only on reset.
REQ-031 chnl_valid SHALL equal the registered HOLD-state flag.
REQ-032 chnl_avail SHALL be 1 when outstd_cnt[owner] < MAX_OUTSTD, where owner is last_grant, and 0 otherwise.
REQ-033 A channel at MAX_OUTSTD SHALL NOT be granted, and SHALL NOT block other channels.

Reset
REQ-034 While rst_n=0: FSM=ARB, last_grant=CHNL_NUM-1, all outstd_cnt=0, rd_req_head=0, outstd_err=0.
REQ-035 While rst_n=0: rd_req_valid=0, chnl_req_ready=0, chnl_valid=0, and chnl_avail=1.
REQ-036 Reset asserted during HOLD SHALL drop the pending request without presenting it again; counters SHALL reset to 0.

Verification
REQ-037 Scenario: all 4 channels valid continuously, rd_req_ready=1 -> grant order 0,1,2,3,0; rd_req_valid pattern 0,1,0,1; head[127:120] = 0,1,2,3.
REQ-038 Scenario: channel 2 only, rd_req_ready held 0 for 5 cycles -> rd_req_valid stays 1 and rd_req_head stays stable; chnl_req_ready all 0 during the hold; accept completes on the 6th cycle.
REQ-039 Scenario: MAX_OUTSTD=2, channel 1 issues 2 requests without completions -> third request not accepted, chnl_avail=0 in the second HOLD; one cpl_done_chnl=1 pulse -> channel 1 granted on the next ARB cycle.
REQ-040 Scenario: channel 0 accepted and cpl_done_chnl=0 in the same cycle, with count 1 -> count remains 1.
REQ-041 Scenario: cpl_done_chnl=3 with count 0, then cpl_done_chnl=9 -> counts unchanged, outstd_err=1 and held until rst_n=0.
REQ-042 Scenario: rst_n pulsed low during HOLD -> rd_req_valid=0 asynchronously, counts 0, and after release channel 0 wins first.
